// File: rtl/spike_pkg.sv
// Shared types, default widths and helpers for the spike-train decoder.
package spike_pkg;

  localparam int unsigned WIN_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } dec_state_t;

  // Saturating increment used by both the window spike count and the ISI gap counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input logic [31:0] max);
    if (!inc)
      return val;
    else if (val >= max)
      return max;
    else
      return val + 32'd1;
  endfunction

endpackage

// File: rtl/spike_edge_det.sv
// Registers the spike level and flags its rising edge; shared with the LIF neuron top.
module spike_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic spike_in,
  output logic spike_rise
);

  logic spike_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      spike_q <= 1'b0;
    else
      spike_q <= spike_in;
  end

  assign spike_rise = spike_in & ~spike_q;

endmodule

// File: rtl/spike_decoder.sv
// Converts a spike train into a per-window firing rate and an inter-spike interval,
// each presented as a registered value with a one-cycle valid strobe.
module spike_decoder
  import spike_pkg::*;
#(
  parameter int unsigned WIN_W = WIN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic [CNT_W-1:0] isi_out,
  output logic             isi_valid
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  dec_state_t       state, state_nxt;
  logic             rise;
  logic             first_cyc;
  logic             isi_fire;
  logic             win_last;
  logic [WIN_W-1:0] lim_q;
  logic [WIN_W-1:0] lim_cur;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] gap;

  spike_edge_det u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .spike_rise (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!ena)
      state_nxt = IDLE;
    else if (state == RUN || rise)
      state_nxt = RUN;
    else
      state_nxt = ARMED;
  end

  always_comb begin
    first_cyc = 1'b0;
    isi_fire  = 1'b0;
    if (ena) begin
      first_cyc = (state == IDLE);
      isi_fire  = (state == RUN) && rise;
    end
  end

  // On the first enabled cycle the limit register is stale, so use win_len directly.
  // A limit of 0 wraps L-1 to all ones, giving the 2^WIN_W window for free.
  assign lim_cur  = first_cyc ? win_len : lim_q;
  assign win_last = (win_cnt == lim_cur - WIN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lim_q      <= '0;
      win_cnt    <= '0;
      cnt        <= '0;
      gap        <= '0;
      rate_out   <= '0;
      rate_sat   <= 1'b0;
      rate_valid <= 1'b0;
      isi_out    <= '0;
      isi_valid  <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      isi_valid  <= 1'b0;
      if (!ena) begin
        win_cnt <= '0;
        cnt     <= '0;
        gap     <= '0;
      end else begin
        if (win_last) begin
          rate_out   <= CNT_W'(sat_inc(32'(cnt), rise, CNT_MAX));
          rate_sat   <= rise && (32'(cnt) == CNT_MAX);
          rate_valid <= 1'b1;
          cnt        <= '0;
          win_cnt    <= '0;
          lim_q      <= win_len;
        end else begin
          cnt     <= CNT_W'(sat_inc(32'(cnt), rise, CNT_MAX));
          win_cnt <= win_cnt + WIN_W'(1);
          if (first_cyc)
            lim_q <= win_len;
        end
        gap <= rise ? CNT_W'(1) : CNT_W'(sat_inc(32'(gap), 1'b1, CNT_MAX));
        if (isi_fire) begin
          isi_out   <= gap;
          isi_valid <= 1'b1;
        end
      end
    end
  end

endmodule
